pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DW, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter SKID, default 1: 0 selects a single-register stage, 1 selects a two-entry skid stage.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port aclr  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream payload present.
REQ-006 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-007 SHALL have port in_data  input  DW  upstream payload.
REQ-008 SHALL have port flush  input  1  synchronous discard of all held and incoming payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a payload.
REQ-010 SHALL have port out_ready  input  1  downstream accepts payload this cycle.
REQ-011 SHALL have port out_data  output  DW  payload presented downstream.
REQ-012 SHALL have port occupancy  output  2  number of payloads held, 0..2.

Function
REQ-013 SHALL count an input transfer when in_valid and in_ready are both 1 at a clk edge.
REQ-014 SHALL count an output transfer when out_valid and out_ready are both 1 at a clk edge.
REQ-015 SHALL hold a main register M (valid bit plus data) that drives out_valid and out_data directly.
REQ-016 SHALL hold a skid register S (valid bit plus data) when SKID=1; S SHALL be absent when SKID=0.
REQ-017 SHALL deliver payloads downstream in acceptance order, with none lost or duplicated.
REQ-018 SHALL give one cycle of latency: a payload accepted into an empty stage appears on out_data at the next edge.
REQ-019 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0, unless flush or aclr is active.
REQ-020 SHALL, when SKID=0, drive in_ready combinationally as out_ready OR NOT M.valid, giving full throughput; occupancy SHALL be 0 or 1.
REQ-021 SHALL, when SKID=1, drive in_ready directly from a register as NOT S.valid, with no combinational path from out_ready.
REQ-022 SHALL, when SKID=1, implement states EMPTY (M=0,S=0), ONE (M=1,S=0) and FULL (M=1,S=1); M=0 with S=1 SHALL be unreachable.
REQ-023 SHALL go from EMPTY to ONE on an input transfer, loading M.
REQ-024 SHALL, in ONE with input and output transfer together, stay in ONE and load M with the new payload.
REQ-025 SHALL, in ONE with output transfer only, go to EMPTY.
REQ-026 SHALL, in ONE with input transfer only, go to FULL, loading S with the new payload while M is unchanged.
REQ-027 SHALL, in FULL, never accept input (in_ready=0).
REQ-028 SHALL, in FULL with an output transfer, move S to M and go to ONE.
REQ-029 SHALL, when flush=1 at an edge, clear M.valid and S.valid, discard any same-cycle input transfer, and ignore out_ready for state update (highest priority).
REQ-030 SHALL treat the downstream handshake as completed normally if out_ready=1 on the flush edge.
REQ-031 SHALL leave data registers unchanged on flush; only the valid bits clear.
REQ-032 SHALL drive occupancy as M.valid plus S.valid.

Reset
REQ-033 SHALL, while aclr=1, immediately and asynchronously clear M.valid and S.valid and set M.data and S.data to 0.
REQ-034 SHALL, during reset, drive out_valid=0, out_data=0 and occupancy=0.
REQ-035 SHALL, during reset, drive in_ready=1 when SKID=1, and drive in_ready equal to out_ready OR 1 (that is, 1) when SKID=0.
REQ-036 SHALL, on aclr asserted mid-operation, lose all held payloads; the first edge after release SHALL behave as EMPTY.
REQ-037 SHALL accept no input transfer at any edge where aclr=1.

Verification
REQ-038 Bench SHALL cover, with DW=8 and SKID=1, streaming: out_ready=1, in_valid=1 and data 0x01,0x02,0x03 on consecutive edges -> out_data shows 0x01,0x02,0x03 one cycle later each, and in_ready stays 1.
REQ-039 Bench SHALL cover backpressure: in state ONE holding 0xA5, out_ready=0, input 0x5A accepted -> occupancy=2 and in_ready=0; raising out_ready -> 0xA5 then 0x5A delivered and in_ready returns to 1.
REQ-040 Bench SHALL cover flush in FULL with a same-cycle in_valid=1 carrying 0x77 -> next cycle out_valid=0, occupancy=0, and 0x77 never appears.
REQ-041 Bench SHALL cover asynchronous reset: aclr pulsed between edges while FULL -> out_valid=0, out_data=0, occupancy=0 before the next edge.
REQ-042 Bench SHALL cover SKID=0 stall: M holds 0x3C with out_ready=0 -> in_ready=0 and 0x3C held; out_ready=1 with in_valid=1 carrying 0x3D -> 0x3D on out_data next cycle.
REQ-043 Bench SHALL include a random ready/valid scoreboard run of 10000 cycles for both SKID values, checking order, no loss and no duplication.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Ready/valid pipeline stage, either a single register
//               (SKID=0) or a two-entry skid buffer with registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int DW   = 32,
  parameter int SKID = 1
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
      } state_t;

      state_t        state_q, state_d;
      logic          m_valid_q;
      logic          s_valid_q;
      logic          ready_q;
      logic [DW-1:0] m_data_q, m_data_d;
      logic [DW-1:0] s_data_q, s_data_d;

      always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (flush) begin
          state_d = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_xfer) begin
                state_d  = ST_ONE;
                m_data_d = in_data;
              end
            end
            ST_ONE: begin
              if (in_xfer && out_xfer) begin
                m_data_d = in_data;
              end else if (out_xfer) begin
                state_d = ST_EMPTY;
              end else if (in_xfer) begin
                state_d  = ST_FULL;
                s_data_d = in_data;
              end
            end
            ST_FULL: begin
              if (out_xfer) begin
                state_d  = ST_ONE;
                m_data_d = s_data_q;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      // Valid bits and in_ready are kept as flops decoded from the next
      // state so the upstream sees no combinational path from out_ready.
      always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
          state_q   <= ST_EMPTY;
          m_valid_q <= 1'b0;
          s_valid_q <= 1'b0;
          ready_q   <= 1'b1;
          m_data_q  <= '0;
          s_data_q  <= '0;
        end else begin
          state_q   <= state_d;
          m_valid_q <= (state_d != ST_EMPTY);
          s_valid_q <= (state_d == ST_FULL);
          ready_q   <= (state_d != ST_FULL);
          m_data_q  <= m_data_d;
          s_data_q  <= s_data_d;
        end
      end

      assign in_ready  = ready_q;
      assign out_valid = m_valid_q;
      assign out_data  = m_data_q;
      assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    end else begin : g_single
      logic          m_valid_q, m_valid_d;
      logic [DW-1:0] m_data_q, m_data_d;

      always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (flush) begin
          m_valid_d = 1'b0;
        end else if (in_xfer) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end else if (out_xfer) begin
          m_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
          m_valid_q <= 1'b0;
          m_data_q  <= '0;
        end else begin
          m_valid_q <= m_valid_d;
          m_data_q  <= m_data_d;
        end
      end

      assign in_ready  = out_ready | ~m_valid_q;
      assign out_valid = m_valid_q;
      assign out_data  = m_data_q;
      assign occupancy = {1'b0, m_valid_q};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Bench for pipe_stage_skid, SKID=1 and SKID=0 side by side,
//               against a queue model of the held payloads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic       clk;
  logic       aclr;
  logic       chk_en;
  int         total;
  int         bad;

  logic       in_valid1, in_ready1, flush1, out_valid1, out_ready1;
  logic [7:0] in_data1, out_data1;
  logic [1:0] occupancy1;
  logic       in_valid0, in_ready0, flush0, out_valid0, out_ready0;
  logic [7:0] in_data0, out_data0;
  logic [1:0] occupancy0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];

  pipe_stage_skid #(.DW(8), .SKID(1)) u_dut1 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .flush(flush1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .occupancy(occupancy1)
  );

  pipe_stage_skid #(.DW(8), .SKID(0)) u_dut0 (
    .clk(clk), .aclr(aclr), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .flush(flush0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_data(out_data0), .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a stage is just a FIFO of held payloads, capacity 2 (SKID=1) or 1.
  always @(posedge clk) begin
    if (aclr) begin
      q1.delete();
      q0.delete();
    end else begin
      logic ir1, ov1, ir0, ov0;
      ir1 = (q1.size() < 2);
      ov1 = (q1.size() != 0);
      ir0 = out_ready0 || (q0.size() == 0);
      ov0 = (q0.size() != 0);
      if (flush1) q1.delete();
      else begin
        if (ov1 && out_ready1) void'(q1.pop_front());
        if (in_valid1 && ir1) q1.push_back(in_data1);
      end
      if (flush0) q0.delete();
      else begin
        if (ov0 && out_ready0) void'(q0.pop_front());
        if (in_valid0 && ir0) q0.push_back(in_data0);
      end
    end
  end

  always @(posedge aclr) begin
    q1.delete();
    q0.delete();
  end

  always @(negedge clk) begin
    if (chk_en && !aclr) begin
      chk("d1_out_valid", 32'(out_valid1), 32'(q1.size() != 0));
      if (q1.size() != 0) chk("d1_out_data", 32'(out_data1), 32'(q1[0]));
      chk("d1_occupancy", 32'(occupancy1), 32'(q1.size()));
      chk("d1_in_ready", 32'(in_ready1), 32'(q1.size() < 2));
      chk("d0_out_valid", 32'(out_valid0), 32'(q0.size() != 0));
      if (q0.size() != 0) chk("d0_out_data", 32'(out_data0), 32'(q0[0]));
      chk("d0_occupancy", 32'(occupancy0), 32'(q0.size()));
      chk("d0_in_ready", 32'(in_ready0), 32'(out_ready0 || (q0.size() == 0)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_d1_out_valid"}, 32'(out_valid1), 32'd0);
    chk({tag, "_d1_out_data"},  32'(out_data1),  32'd0);
    chk({tag, "_d1_occupancy"}, 32'(occupancy1), 32'd0);
    chk({tag, "_d1_in_ready"},  32'(in_ready1),  32'd1);
    chk({tag, "_d0_out_valid"}, 32'(out_valid0), 32'd0);
    chk({tag, "_d0_out_data"},  32'(out_data0),  32'd0);
    chk({tag, "_d0_occupancy"}, 32'(occupancy0), 32'd0);
    chk({tag, "_d0_in_ready"},  32'(in_ready0),  32'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    chk_en = 1'b0;
    aclr = 1'b1;
    in_valid1 = 0; in_data1 = 0; flush1 = 0; out_ready1 = 0;
    in_valid0 = 0; in_data0 = 0; flush0 = 0; out_ready0 = 0;
    #12;
    chk_reset_outputs("reset");
    #1;
    aclr = 1'b0;
    chk_en = 1'b1;

    // Streaming through the skid stage.
    out_ready1 = 1; in_valid1 = 1; in_data1 = 8'h01;
    tick();
    chk("stream_d01", 32'(out_data1), 32'h01);
    chk("stream_rdy1", 32'(in_ready1), 32'd1);
    in_data1 = 8'h02;
    tick();
    chk("stream_d02", 32'(out_data1), 32'h02);
    in_data1 = 8'h03;
    tick();
    chk("stream_d03", 32'(out_data1), 32'h03);
    chk("stream_rdy3", 32'(in_ready1), 32'd1);
    in_valid1 = 0;
    tick();
    chk("stream_empty", 32'(out_valid1), 32'd0);

    // Backpressure into FULL and drain.
    out_ready1 = 0; in_valid1 = 1; in_data1 = 8'hA5;
    tick();
    chk("bp_one_data", 32'(out_data1), 32'hA5);
    in_data1 = 8'h5A;
    tick();
    chk("bp_full_occ", 32'(occupancy1), 32'd2);
    chk("bp_full_rdy", 32'(in_ready1), 32'd0);
    chk("bp_full_hold", 32'(out_data1), 32'hA5);
    in_valid1 = 0; out_ready1 = 1;
    tick();
    chk("bp_drain_5a", 32'(out_data1), 32'h5A);
    chk("bp_drain_rdy", 32'(in_ready1), 32'd1);
    tick();
    chk("bp_drained", 32'(out_valid1), 32'd0);

    // Flush while FULL with a same-cycle input.
    out_ready1 = 0; in_valid1 = 1; in_data1 = 8'h11;
    tick();
    in_data1 = 8'h22;
    tick();
    chk("fl_full_occ", 32'(occupancy1), 32'd2);
    flush1 = 1; in_data1 = 8'h77;
    tick();
    flush1 = 0; in_valid1 = 0;
    chk("fl_valid", 32'(out_valid1), 32'd0);
    chk("fl_occ", 32'(occupancy1), 32'd0);
    out_ready1 = 1;
    repeat (3) begin
      tick();
      chk("fl_no_77", 32'(out_valid1), 32'd0);
    end

    // Asynchronous reset between edges while FULL.
    out_ready1 = 0; in_valid1 = 1; in_data1 = 8'h33;
    tick();
    in_data1 = 8'h44;
    tick();
    chk("ar_full_occ", 32'(occupancy1), 32'd2);
    in_valid1 = 0;
    #2 aclr = 1'b1;
    #1 chk_reset_outputs("areset");
    #1 aclr = 1'b0;
    tick();
    chk("ar_after_empty", 32'(out_valid1), 32'd0);

    // Single-register stall and full-throughput replace.
    out_ready0 = 0; in_valid0 = 1; in_data0 = 8'h3C;
    tick();
    chk("s0_hold_data", 32'(out_data0), 32'h3C);
    in_data0 = 8'h99;
    #1 chk("s0_stall_rdy", 32'(in_ready0), 32'd0);
    tick();
    chk("s0_still_3c", 32'(out_data0), 32'h3C);
    out_ready0 = 1; in_data0 = 8'h3D;
    #1 chk("s0_pass_rdy", 32'(in_ready0), 32'd1);
    tick();
    chk("s0_got_3d", 32'(out_data0), 32'h3D);
    chk("s0_valid", 32'(out_valid0), 32'd1);
    in_valid0 = 0;
    tick();

    // Random traffic on both stages; the per-cycle compare does the checking.
    for (int i = 0; i < 10000; i++) begin
      in_valid1  = ($urandom_range(0, 3) != 0);
      in_data1   = 8'($urandom_range(0, 255));
      out_ready1 = (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush1     = ($urandom_range(0, 63) == 0);
      in_valid0  = ($urandom_range(0, 3) != 0);
      in_data0   = 8'($urandom_range(0, 255));
      out_ready0 = (i < 5000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush0     = ($urandom_range(0, 63) == 0);
      tick();
    end

    in_valid1 = 0; flush1 = 0; out_ready1 = 1;
    in_valid0 = 0; flush0 = 0; out_ready0 = 1;
    repeat (4) tick();
    chk("final_d1_empty", 32'(out_valid1), 32'd0);
    chk("final_d0_empty", 32'(out_valid0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
